// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: song-load, playback-control and note-output signals of the melody sequencer
interface melody_sequencer_if #(parameter int ADDR_W = 7);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [19:0]       wr_data;
  logic [ADDR_W:0]   song_len;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [15:0]       freq_out;
  logic              tone_on;
  logic              note_strobe;
  logic [ADDR_W-1:0] cur_addr;
  logic              busy;
  logic              done;
  modport master (
    output wr_en, wr_addr, wr_data, song_len, start, stop, loop_en,
    input  freq_out, tone_on, note_strobe, cur_addr, busy, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, song_len, start, stop, loop_en,
    output freq_out, tone_on, note_strobe, cur_addr, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps a writable (freq, length) song RAM on a fixed tick and feeds the tone generator.
// Define MELODY_ARTICULATION_EN to silence tone_on for the last GAP_CYCLES cycles of each sounded note.
module melody_sequencer #(
  parameter int STEP_CYCLES = 4_500_000,
  parameter int ADDR_W      = 7,
  parameter int GAP_CYCLES  = 450_000
) (
  input logic          clk,
  input logic          rst,
  melody_sequencer_if.slave bus
);
  localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
  localparam int LW = ADDR_W + 1;
  localparam logic [LW-1:0] DEPTH   = LW'(2 ** ADDR_W);
  localparam logic [SW-1:0] STEP_LD = SW'(STEP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;
  state_t state, state_n;
  logic [19:0] mem [2**ADDR_W];
  logic [19:0] rd_data;
  logic [ADDR_W-1:0] cur_addr, addr_n;
  logic [LW-1:0] len, len_n;
  logic [15:0] freq, freq_n;
  logic tone, tone_n, strobe, strobe_n, done, done_n;
  logic [SW-1:0] step_cnt, step_n;
  logic [3:0] step_idx, idx_n, len_m1, lm1_n, lat_m1;
  logic last;
`ifdef MELODY_ARTICULATION_EN
  localparam int RW = $clog2(16 * STEP_CYCLES + 1);
  localparam logic [31:0] GAP = 32'(GAP_CYCLES);
  logic [RW-1:0] rem, rem_n, rem_ld;
  assign rem_ld = RW'({1'b0, lat_m1} + 5'd1) * RW'(STEP_CYCLES);
`endif
  // Read port always follows cur_addr; a same-cycle write to that entry yields the old word.
  always_ff @(posedge clk) begin
    if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    rd_data <= mem[cur_addr];
  end
  assign lat_m1 = rd_data[3:0] == 4'd0 ? 4'd0 : rd_data[3:0] - 4'd1;
  assign last   = {1'b0, cur_addr} == len - LW'(1);
  always_comb begin
    state_n  = state;
    addr_n   = cur_addr;
    len_n    = len;
    freq_n   = freq;
    tone_n   = tone;
    strobe_n = 1'b0;
    done_n   = 1'b0;
    step_n   = step_cnt;
    idx_n    = step_idx;
    lm1_n    = len_m1;
`ifdef MELODY_ARTICULATION_EN
    rem_n    = rem;
`endif
    if (state != IDLE && bus.stop) begin
      state_n = IDLE;
      freq_n  = '0;
      tone_n  = 1'b0;
      addr_n  = '0;
    end else begin
      case (state)
        IDLE: if (bus.start && !bus.stop) begin
          done_n = bus.song_len == '0;
          if (bus.song_len != '0) begin
            len_n   = bus.song_len > DEPTH ? DEPTH : bus.song_len;
            addr_n  = '0;
            state_n = FETCH;
          end
        end
        FETCH: state_n = LATCH;
        LATCH: begin
          freq_n   = rd_data[19:4];
          lm1_n    = lat_m1;
          strobe_n = 1'b1;
          step_n   = STEP_LD;
          idx_n    = '0;
          state_n  = PLAY;
`ifdef MELODY_ARTICULATION_EN
          rem_n    = rem_ld;
          tone_n   = rd_data[19:4] != '0 && 32'(rem_ld) > GAP;
`else
          tone_n   = rd_data[19:4] != '0;
`endif
        end
        PLAY: begin
`ifdef MELODY_ARTICULATION_EN
          // rem counts PLAY cycles left including this one; the gate falls once GAP or fewer remain
          rem_n = rem - RW'(1);
          if (rem > RW'(1)) tone_n = freq != '0 && 32'(rem_n) > GAP;
`endif
          step_n = step_cnt - SW'(1);
          if (step_cnt == '0) begin
            step_n = STEP_LD;
            idx_n  = step_idx + 4'd1;
            if (step_idx == len_m1) begin
              addr_n  = last ? '0 : cur_addr + ADDR_W'(1);
              state_n = last && !bus.loop_en ? IDLE : FETCH;
              if (last && !bus.loop_en) begin
                freq_n = '0;
                tone_n = 1'b0;
                done_n = 1'b1;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_addr <= '0;
      len      <= '0;
      freq     <= '0;
      tone     <= 1'b0;
      strobe   <= 1'b0;
      done     <= 1'b0;
      step_cnt <= '0;
      step_idx <= '0;
      len_m1   <= '0;
    end else begin
      state    <= state_n;
      cur_addr <= addr_n;
      len      <= len_n;
      freq     <= freq_n;
      tone     <= tone_n;
      strobe   <= strobe_n;
      done     <= done_n;
      step_cnt <= step_n;
      step_idx <= idx_n;
      len_m1   <= lm1_n;
    end
  end
`ifdef MELODY_ARTICULATION_EN
  always_ff @(posedge clk) begin
    if (rst) rem <= '0;
    else rem <= rem_n;
  end
`endif
  assign bus.freq_out    = freq;
  assign bus.tone_on     = tone;
  assign bus.note_strobe = strobe;
  assign bus.cur_addr    = cur_addr;
  assign bus.busy        = state != IDLE;
  assign bus.done        = done;
endmodule
